// File: rtl/river_pkg.sv
// Shared definitions for the machine-mode trap/return sequencer:
// cause codes, CSR bit positions, FSM state encoding and the
// MSTATUS update helpers used when a trap or MRET is taken.
package river_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMMIT   = 2'd1,
    REDIRECT = 2'd2
  } exc_state_e;

  // Synchronous exception cause codes (MCAUSE[31] = 0)
  localparam logic [3:0] CAUSE_INST_MISALIGNED  = 4'd0;
  localparam logic [3:0] CAUSE_INST_FAULT       = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL          = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
  localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] CAUSE_LOAD_FAULT       = 4'd5;
  localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] CAUSE_STORE_FAULT      = 4'd7;
  localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;

  // Interrupt cause codes (MCAUSE[31] = 1)
  localparam logic [3:0] CODE_IRQ_SW    = 4'd3;
  localparam logic [3:0] CODE_IRQ_TIMER = 4'd7;
  localparam logic [3:0] CODE_IRQ_EXT   = 4'd11;

  // Bit positions of the incoming EXC_FLAGS_SM vector
  localparam int EXC_INST_MISALIGNED  = 0;
  localparam int EXC_INST_FAULT       = 1;
  localparam int EXC_ILLEGAL          = 2;
  localparam int EXC_EBREAK           = 3;
  localparam int EXC_LOAD_MISALIGNED  = 4;
  localparam int EXC_LOAD_FAULT       = 5;
  localparam int EXC_STORE_MISALIGNED = 6;
  localparam int EXC_STORE_FAULT      = 7;

  // Bit positions of the IRQ_I vector
  localparam int IRQ_SW    = 0;
  localparam int IRQ_TIMER = 1;
  localparam int IRQ_EXT   = 2;

  // MSTATUS fields
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // MIE / MIP bit positions
  localparam int MIP_MSIP = 3;
  localparam int MIP_MTIP = 7;
  localparam int MIP_MEIP = 11;

  localparam logic [1:0]  TVEC_VECTORED = 2'b01;
  localparam logic [31:0] INST_ECALL    = 32'h0000_0073;

  // Trap entry: stash MIE into MPIE, disable interrupts, MPP = machine
  function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // Trap return: restore MIE from MPIE, set MPIE, MPP stays machine-only
  function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // Address-class causes report the faulting address, illegal reports the
  // instruction word, everything else reports zero
  function automatic logic [31:0] sync_mtval(input logic [3:0]  cause,
                                             input logic [31:0] adr,
                                             input logic [31:0] inst);
    logic [31:0] r;
    case (cause)
      CAUSE_INST_MISALIGNED, CAUSE_INST_FAULT,
      CAUSE_LOAD_MISALIGNED, CAUSE_LOAD_FAULT,
      CAUSE_STORE_MISALIGNED, CAUSE_STORE_FAULT: r = adr;
      CAUSE_ILLEGAL:                             r = inst;
      default:                                   r = 32'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/exception_unit_irq_sync.sv
// Multi-flop synchronizer for the three asynchronous interrupt lines.
module irq_sync
  import river_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] irq_i,
  output logic [2:0] irq_o
);

  logic [SYNC_STAGES-1:0][2:0] sync_q;

  // Shift each IRQ line through SYNC_STAGES flops; index 0 is the capture flop
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
    end
  end

  assign irq_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/exception_unit.sv
// Machine-mode trap and MRET sequencer at the memory stage. An accepted
// event is captured in IDLE, the CSR write strobe fires in COMMIT and the
// fetch redirect fires in REDIRECT, with the pipeline flushed in both.
module exception_unit
  import river_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        VALID_SM,
  input  logic [31:0] PC_SM,
  input  logic [31:0] INST_SM,
  input  logic [31:0] ADR_SM,
  input  logic [7:0]  EXC_FLAGS_SM,
  input  logic        MRET_SM,
  input  logic [2:0]  IRQ_I,
  input  logic [31:0] MSTATUS_RC,
  input  logic [31:0] MTVEC_VALUE_RC,
  input  logic [31:0] MIE_VALUE_RC,
  input  logic [31:0] MEPC_SC,
  output logic        EXCEPTION_SM,
  output logic [31:0] MSTATUS_WDATA_SM,
  output logic [31:0] MEPC_WDATA_SM,
  output logic [31:0] MCAUSE_WDATA_SM,
  output logic [31:0] MTVAL_WDATA_SM,
  output logic [31:0] MIP_WDATA_SM,
  output logic        FLUSH_SE,
  output logic        REDIRECT_VALID_SE,
  output logic [31:0] REDIRECT_PC_SE
);

  logic [2:0]  irq_sync_w;
  logic [2:0]  irq_pend;
  logic [3:0]  irq_code;
  logic [3:0]  sync_code;
  logic        take_irq;
  logic        take_sync;
  logic        is_ecall;
  logic        accept;
  logic [31:0] tvec_base;

  logic [31:0] mstatus_d, mepc_d, mcause_d, mtval_d, mip_d, target_d;

  exc_state_e  state_q;
  logic        exc_q, flush_q, redir_q;
  logic [31:0] mstatus_q, mepc_q, mcause_q, mtval_q, mip_q, target_q;

  // Only bits 3/7/11 of MIE gate interrupts; the rest are intentionally ignored
  logic unused_mie;
  assign unused_mie = ^MIE_VALUE_RC;

  irq_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_irq_sync (
    .clk   (clk),
    .reset (reset),
    .irq_i (IRQ_I),
    .irq_o (irq_sync_w)
  );

  // Event arbitration and CSR write-data formation for a candidate event
  always_comb begin
    irq_pend = irq_sync_w
             & {MIE_VALUE_RC[MIP_MEIP], MIE_VALUE_RC[MIP_MTIP], MIE_VALUE_RC[MIP_MSIP]}
             & {3{MSTATUS_RC[MSTATUS_MIE]}};
    take_irq = |irq_pend;

    irq_code = CODE_IRQ_TIMER;
    if (irq_pend[IRQ_EXT])     irq_code = CODE_IRQ_EXT;
    else if (irq_pend[IRQ_SW]) irq_code = CODE_IRQ_SW;

    is_ecall  = (EXC_FLAGS_SM == 8'h00) && (INST_SM == INST_ECALL);
    take_sync = (|EXC_FLAGS_SM) || is_ecall;

    sync_code = CAUSE_STORE_FAULT;
    if (EXC_FLAGS_SM[EXC_INST_FAULT])            sync_code = CAUSE_INST_FAULT;
    else if (EXC_FLAGS_SM[EXC_ILLEGAL])          sync_code = CAUSE_ILLEGAL;
    else if (EXC_FLAGS_SM[EXC_INST_MISALIGNED])  sync_code = CAUSE_INST_MISALIGNED;
    else if (is_ecall)                           sync_code = CAUSE_ECALL_M;
    else if (EXC_FLAGS_SM[EXC_EBREAK])           sync_code = CAUSE_BREAKPOINT;
    else if (EXC_FLAGS_SM[EXC_LOAD_MISALIGNED])  sync_code = CAUSE_LOAD_MISALIGNED;
    else if (EXC_FLAGS_SM[EXC_STORE_MISALIGNED]) sync_code = CAUSE_STORE_MISALIGNED;
    else if (EXC_FLAGS_SM[EXC_LOAD_FAULT])       sync_code = CAUSE_LOAD_FAULT;

    accept = VALID_SM && (take_irq || take_sync || MRET_SM);

    tvec_base = {MTVEC_VALUE_RC[31:2], 2'b00};

    mip_d           = 32'h0;
    mip_d[MIP_MSIP] = irq_sync_w[IRQ_SW];
    mip_d[MIP_MTIP] = irq_sync_w[IRQ_TIMER];
    mip_d[MIP_MEIP] = irq_sync_w[IRQ_EXT];

    mstatus_d = trap_mstatus(MSTATUS_RC);
    mepc_d    = PC_SM;
    mcause_d  = 32'h0;
    mtval_d   = 32'h0;
    target_d  = tvec_base;

    if (take_irq) begin
      mcause_d = {1'b1, 27'b0, irq_code};
      if (MTVEC_VALUE_RC[1:0] == TVEC_VECTORED)
        target_d = tvec_base + {26'b0, irq_code, 2'b00};
    end else if (take_sync) begin
      mcause_d = {28'b0, sync_code};
      mtval_d  = sync_mtval(sync_code, ADR_SM, INST_SM);
    end else begin
      // MRET: MCAUSE/MTVAL have no read port here, so re-send the last
      // values this unit wrote, which is what those CSRs hold
      mstatus_d = mret_mstatus(MSTATUS_RC);
      mepc_d    = MEPC_SC;
      mcause_d  = mcause_q;
      mtval_d   = mtval_q;
      target_d  = {MEPC_SC[31:2], 2'b00};
    end
  end

  // Sequencer: capture in IDLE, CSR strobe in COMMIT, redirect in REDIRECT
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      exc_q     <= 1'b0;
      flush_q   <= 1'b0;
      redir_q   <= 1'b0;
      mstatus_q <= 32'h0;
      mepc_q    <= 32'h0;
      mcause_q  <= 32'h0;
      mtval_q   <= 32'h0;
      mip_q     <= 32'h0;
      target_q  <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= COMMIT;
            exc_q     <= 1'b1;
            flush_q   <= 1'b1;
            mstatus_q <= mstatus_d;
            mepc_q    <= mepc_d;
            mcause_q  <= mcause_d;
            mtval_q   <= mtval_d;
            mip_q     <= mip_d;
            target_q  <= target_d;
          end
        end
        COMMIT: begin
          state_q <= REDIRECT;
          exc_q   <= 1'b0;
          redir_q <= 1'b1;
        end
        REDIRECT: begin
          state_q <= IDLE;
          redir_q <= 1'b0;
          flush_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          exc_q   <= 1'b0;
          redir_q <= 1'b0;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  assign EXCEPTION_SM      = exc_q;
  assign FLUSH_SE          = flush_q;
  assign REDIRECT_VALID_SE = redir_q;
  assign REDIRECT_PC_SE    = target_q;
  assign MSTATUS_WDATA_SM  = mstatus_q;
  assign MEPC_WDATA_SM     = mepc_q;
  assign MCAUSE_WDATA_SM   = mcause_q;
  assign MTVAL_WDATA_SM    = mtval_q;
  assign MIP_WDATA_SM      = mip_q;

endmodule

// File: doc/exception_unit.md
EXCEPTION_UNIT -- requirements
Module: exception_unit

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops on each IRQ_I line (legal values 2..3).
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 VALID_SM  in  1  an instruction occupies the memory stage this cycle.
REQ-005 PC_SM  in  32  PC of the memory-stage instruction.
REQ-006 INST_SM  in  32  instruction word of the memory-stage instruction.
REQ-007 ADR_SM  in  32  faulting fetch/load/store address.
REQ-008 EXC_FLAGS_SM  in  8  [0] instr misaligned, [1] instr access fault, [2] illegal, [3] ebreak, [4] load misaligned, [5] load fault, [6] store misaligned, [7] store fault; ecall SHALL arrive as [8]? no -- ecall is INST_SM==32'h00000073 with flags clear.
REQ-009 MRET_SM  in  1  memory-stage instruction is MRET.
REQ-010 IRQ_I  in  3  asynchronous level interrupts: [0] software, [1] timer, [2] external.
REQ-011 MSTATUS_RC / MTVEC_VALUE_RC / MIE_VALUE_RC / MEPC_SC  in  32 each  current CSR values.
REQ-012 EXCEPTION_SM  out  1  one-cycle CSR trap-write strobe.
REQ-013 MSTATUS_WDATA_SM / MEPC_WDATA_SM / MCAUSE_WDATA_SM / MTVAL_WDATA_SM / MIP_WDATA_SM  out  32 each  CSR write data, valid with EXCEPTION_SM.
REQ-014 FLUSH_SE  out  1  squash all stages upstream of writeback.
REQ-015 REDIRECT_VALID_SE  out  1  fetch redirect strobe.
REQ-016 REDIRECT_PC_SE  out  32  redirect target.

Function
REQ-017 FSM states SHALL be IDLE, COMMIT, REDIRECT; IDLE->COMMIT on an accepted event, COMMIT->REDIRECT and REDIRECT->IDLE unconditionally; events SHALL be ignored outside IDLE.
REQ-018 An event SHALL be accepted only when VALID_SM=1; priority: interrupt > synchronous exception > MRET.
REQ-019 An interrupt SHALL be pending when synced IRQ bit & MIE_VALUE_RC bit (3/7/11) & MSTATUS_RC[3]; priority external(11) > software(3) > timer(7); MCAUSE = {1'b1, 27'b0, code}.
REQ-020 Synchronous priority SHALL be: [1]=1, [2]=2, [0]=0, ecall=11, [3]=3, [4]=4, [6]=6, [5]=5, [7]=7; MCAUSE[31]=0.
REQ-021 MTVAL SHALL be ADR_SM for causes 0,1,4,5,6,7, INST_SM for cause 2, zero otherwise.
REQ-022 Trap MSTATUS SHALL equal MSTATUS_RC with [7]<=old [3], [3]<=0, [12:11]<=2'b11; MEPC SHALL be PC_SM.
REQ-023 MRET MSTATUS SHALL set [3]<=old [7], [7]<=1, [12:11]<=2'b11; MEPC/MCAUSE/MTVAL write data SHALL echo current values so the CSR strobe leaves them unchanged.
REQ-024 On acceptance all write data and the target SHALL be registered in IDLE; in COMMIT EXCEPTION_SM=1 and FLUSH_SE=1; in REDIRECT REDIRECT_VALID_SE=1 and FLUSH_SE=1; latency event-to-redirect SHALL be exactly 2 cycles.
REQ-025 Trap target SHALL be {MTVEC[31:2],2'b00}, plus 4*code when MTVEC[1:0]=2'b01 and the cause is an interrupt; MRET target SHALL be MEPC_SC with [1:0] forced to 0.
REQ-026 MIP_WDATA_SM SHALL carry synced IRQ_I at bits 3/7/11, zero elsewhere.
REQ-027 Outside COMMIT/REDIRECT, EXCEPTION_SM, FLUSH_SE, REDIRECT_VALID_SE SHALL be 0.

Reset
REQ-028 reset SHALL force IDLE, all outputs and holding registers to 0, and synchronizer flops to 0, including when asserted in COMMIT or REDIRECT (no strobe in the following cycle).

Structure
REQ-029 Cause codes, MSTATUS bit positions and the FSM state enum SHALL live in river_pkg.
REQ-030 A sub-module irq_sync (SYNC_STAGES-deep, 3-bit) SHALL hold the interrupt synchronizers.

Verification
REQ-031 Illegal at PC 0x100, INST 0xFFFFFFFF, MTVEC 0x200 -> cycle+1 EXCEPTION_SM, MCAUSE 2, MTVAL 0xFFFFFFFF, MEPC 0x100; cycle+2 redirect 0x200.
REQ-032 Load misaligned ADR 0x1003, MSTATUS 0x8 -> MSTATUS_WDATA 0x1880, MCAUSE 4, MTVAL 0x1003.
REQ-033 IRQ_I=3'b110, MIE 0x888, MSTATUS[3]=1, MTVEC 0x301 -> after sync, MCAUSE 0x8000000B, redirect 0x32C.
REQ-034 MRET with MSTATUS 0x1880, MEPC 0x444 -> MSTATUS_WDATA 0x1888, redirect 0x444.
REQ-035 Exception accepted, reset asserted in COMMIT -> no REDIRECT_VALID_SE, IDLE next cycle; second exception in REDIRECT ignored.
